// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit serializer.
// Holds FSM states, channel codes and counter sizing.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        RUN
    } tx_state_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // FIFO status and enable, frozen on each BCLK rise
    typedef struct packed {
        logic en;
        logic hw;
        logic lw;
    } ctl_t;

    function automatic int cnt_width(input int slot_bits);
        return (slot_bits > 1) ? $clog2(slot_bits) : 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every CLK_DIV clk while run=1.
// Ports: clk, reset_n, run in; bclk, rise_stb, fall_stb out.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic          wrap;

    assign wrap     = run && (div == DW'(CLK_DIV - 1));
    assign rise_stb = wrap && !bclk;
    assign fall_stb = wrap && bclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (!run) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (wrap) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div  <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: pops FIFO words per slot, shifts them out MSB first.
// Ports: clk, reset_n, enable, fifo_dout/hw/lw in; fifo_pop, bclk,
// lrclk, sdata, running, underrun_count out.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int WORD_BITS = 24,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 8,
    parameter int UCNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [WORD_BITS-1:0] fifo_dout,
    input  logic                 fifo_hw,
    input  logic                 fifo_lw,
    output logic                 fifo_pop,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdata,
    output logic                 running,
    output logic [UCNT_BITS-1:0] underrun_count
);

    localparam int KW = cnt_width(SLOT_BITS);

    tx_state_t      state;
    tx_state_t      state_nx;
    ctl_t           ctl;
    logic           clk_run;
    logic           rise_stb;
    logic           fall_stb;
    logic [KW-1:0]  k;
    logic           ch;
    logic           ch_nx;
    logic           started;
    logic           wrap;
    logic           left_bnd;
    logic           pop_nx;
    logic           load_data;
    logic           urun;
    logic [WORD_BITS-1:0] sr;

    assign clk_run = (state != IDLE);
    assign running = (state == RUN);

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (clk_run),
        .bclk     (bclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // First fall after leaving IDLE opens a left slot
    assign wrap = fall_stb &&
                  (!started || k == KW'(SLOT_BITS - 1));
    assign ch_nx    = started ? ~ch : LEFT;
    assign left_bnd = wrap && (ch_nx == LEFT);

    always_comb begin
        state_nx  = state;
        pop_nx    = 1'b0;
        load_data = 1'b0;
        urun      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable)
                    state_nx = PREFILL;
            end
            PREFILL: begin
                if (left_bnd && !ctl.en) begin
                    state_nx = IDLE;
                end else if (left_bnd && ctl.hw) begin
                    state_nx  = RUN;
                    pop_nx    = 1'b1;
                    load_data = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    urun = ctl.lw;
                    if (left_bnd && !ctl.en) begin
                        state_nx = IDLE;
                    end else if (ctl.lw) begin
                        state_nx = PREFILL;
                    end else begin
                        pop_nx    = 1'b1;
                        load_data = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ctl            <= '0;
            k              <= '0;
            ch             <= LEFT;
            started        <= 1'b0;
            sr             <= '0;
            lrclk          <= 1'b0;
            sdata          <= 1'b0;
            fifo_pop       <= 1'b0;
            underrun_count <= '0;
        end else begin
            state    <= state_nx;
            fifo_pop <= pop_nx;
            if (rise_stb)
                ctl <= '{en: enable, hw: fifo_hw, lw: fifo_lw};
            if (urun && underrun_count != '1)
                underrun_count <= underrun_count + 1'b1;
            if (state_nx == IDLE) begin
                k       <= '0;
                ch      <= LEFT;
                started <= 1'b0;
                sr      <= '0;
                lrclk   <= 1'b0;
                sdata   <= 1'b0;
            end else if (wrap) begin
                k       <= '0;
                ch      <= ch_nx;
                lrclk   <= ch_nx;
                started <= 1'b1;
                sdata   <= 1'b0;
                sr      <= load_data ? fifo_dout : '0;
            end else if (fall_stb) begin
                k <= k + 1'b1;
                // new k in 1..WORD_BITS carries data
                if (k < KW'(WORD_BITS)) begin
                    sdata <= sr[WORD_BITS-1];
                    sr    <= sr << 1;
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Downstream consumer of the 16-in/24-out audio sample FIFO.
- Takes 24-bit sample words from the FIFO read port and serialises them onto a standard I2S transmit link (BCLK, LRCLK, SDATA) for the audio codec DAC.
- Paces FIFO consumption with a one-cycle pop per channel slot.
- Uses the FIFO high/low watermarks for prefill and underrun handling.

Parameters:
- WORD_BITS, 24, sample width; must equal the FIFO read word width.
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= WORD_BITS+1.
- CLK_DIV, 8, clk cycles per BCLK half-period; must be >= 2.
- UCNT_BITS, 16, width of the underrun counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  stream enable, synchronous level.
- fifo_dout  in  WORD_BITS  FIFO head word; valid 2 clk after a pop.
- fifo_hw  in  1  FIFO high watermark (almost full).
- fifo_lw  in  1  FIFO low watermark (almost empty).
- fifo_pop  out  1  one-cycle pop request to the FIFO.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data, MSB first.
- running  out  1  high while state is RUN.
- underrun_count  out  UCNT_BITS  saturating underrun event count.

Behaviour:
- Reset (async, reset_n=0): state IDLE; bclk=0, lrclk=0, sdata=0, fifo_pop=0, running=0, underrun_count=0; divider, bit and slot counters 0. Effect is immediate, including mid-frame.
- Divider: counts 0..CLK_DIV-1 while state≠IDLE. On wrap it toggles bclk and emits a rise or fall strobe. All outputs change only on fall strobes (bclk 1→0), except fifo_pop.
- Bit counter: k = 0..SLOT_BITS-1 per slot, advanced on fall strobes. At k=0, lrclk takes the new slot's channel. Sequence is left slot then right slot; a frame is 2 slots.
- sdata per slot:
  - k=0: 0
  - k=1..WORD_BITS: shift-register bit WORD_BITS-k (MSB first, one-BCLK I2S delay)
  - k > WORD_BITS: 0
- Slot boundary: the fall strobe where k wraps to 0.
  - RUN and fifo_lw=0: load the shift register from fifo_dout and assert fifo_pop for exactly that one clk.
  - RUN and fifo_lw=1: underrun. Load zero, no pop, underrun_count += 1 (saturating at all-ones), state goes to PREFILL.
  - PREFILL: load zero, no pop.
- Pop spacing is ≥ 2·CLK_DIV·SLOT_BITS clk, so the FIFO's registered head is settled well before the next load. fifo_pop is never high on two consecutive clk.
- States:
  - IDLE: clocks stopped, outputs low. Goes to PREFILL when enable=1; the divider starts the next clk, and the first fall strobe begins left slot k=0.
  - PREFILL: clocks run, zero frames sent. Goes to RUN only at a left-slot boundary with fifo_hw=1. That same boundary pops and loads real data.
  - RUN: running=1.
- enable=0 in PREFILL or RUN: the current frame completes through the right slot's last bit. At the next left-slot boundary, state goes to IDLE with bclk, lrclk, sdata driven 0 and no pop.
- enable re-asserted before that boundary: the pending stop is cancelled.
- Simultaneous enable=0 and underrun at the same boundary: underrun is counted, state goes to IDLE.
- Channel alignment is always preserved: left data is popped only in left slots, and re-entry to RUN happens only at left-slot boundaries.
- fifo_dout is not inspected except at load instants; X on it outside those instants must not propagate.

Decomposition:
- Package i2s_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, PREFILL, RUN}
  - constants LEFT=1'b0 and RIGHT=1'b1
  - a function computing the counter width $clog2(SLOT_BITS)
- One sub-module, i2s_bclk_gen: divider plus bclk toggle, outputs rise_stb and fall_stb, gated by a run input, async active-low reset.
- The top level holds the FSM, bit/slot counters, shift register and underrun counter.

Test Plan (CLK_DIV=2, SLOT_BITS=32, WORD_BITS=24, so slot = 128 clk):
- Reset mid-stream: assert reset_n=0 during RUN at k=10 → same-cycle bclk, lrclk, sdata, fifo_pop = 0, running=0, underrun_count=0; after release, state is IDLE with outputs held low.
- Prefill: enable=1, fifo_hw=0 for 3 frames, then 1 → bclk period is 4 clk and sdata is all zero with no pops for those frames. At the next left boundary, fifo_pop pulses one clk and running=1.
- Data: in RUN, fifo_dout=24'hA5C3F1 at a left boundary → sdata reads 0 at k=0, then bits 1010_0101_1100_0011_1111_0001 at k=1..24, then zeros at k=25..31; lrclk=0 throughout the slot.
- Alternation: 4 consecutive slots with words 24'h000001, 24'h800000, 24'h123456, 24'hFFFFFF → lrclk sequence 0,1,0,1; exactly 4 pops spaced 128 clk apart; each word appears in its own slot.
- Underrun: fifo_lw=1 at a right-slot boundary → right slot sends zeros, no pop, underrun_count goes 0→1, running drops. With fifo_lw=0 and fifo_hw=1, the next left boundary returns to RUN. Preload underrun_count to 16'hFFFF, force one more underrun → count stays 16'hFFFF.
- Stop: deassert enable at left slot k=5 → the right slot completes; at the following left boundary there is no pop, bclk stops low, and the state is IDLE.
